// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [XLEN-1:0]       id_rs1_data_i,
    input  logic [XLEN-1:0]       id_rs2_data_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic [2:0]            id_funct3_i,
    input  logic                  id_funct7b5_i,
    input  logic                  id_reg_write_en_i,
    input  logic                  id_mem_read_en_i,
    input  logic                  id_mem_write_en_i,
    input  logic                  id_mem_to_reg_i,
    input  logic                  id_alu_src_select_i,
    input  logic                  id_branch_en_i,
    input  logic [1:0]            id_alu_op_control_i,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    output logic                  ex_valid_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [XLEN-1:0]       ex_rs1_data_o,
    output logic [XLEN-1:0]       ex_rs2_data_o,
    output logic [XLEN-1:0]       ex_imm_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic [2:0]            ex_funct3_o,
    output logic                  ex_funct7b5_o,
    output logic                  ex_reg_write_en_o,
    output logic                  ex_mem_read_en_o,
    output logic                  ex_mem_write_en_o,
    output logic                  ex_mem_to_reg_o,
    output logic                  ex_alu_src_select_o,
    output logic                  ex_branch_en_o,
    output logic [1:0]            ex_alu_op_control_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]           bubble_count_o,
    output logic [31:0]           flush_count_o,
`endif
    output logic                  load_use_stall_o
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [2:0]            funct3;
        logic                  funct7b5;
    } data_t;

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t state_q, state_d;
    ctrl_t  id_ctrl, ex_ctrl_q;
    data_t  id_data, ex_data_q;
    logic   ex_valid_q;
    logic   advance, rs2_used, hazard;

    // x0 is never written, so the write enable is dropped at capture time
    assign id_ctrl = '{
        reg_write:  id_reg_write_en_i & (id_rd_addr_i != '0),
        mem_read:   id_mem_read_en_i,
        mem_write:  id_mem_write_en_i,
        mem_to_reg: id_mem_to_reg_i,
        alu_src:    id_alu_src_select_i,
        branch:     id_branch_en_i,
        alu_op:     id_alu_op_control_i
    };

    assign id_data = '{
        pc:       id_pc_i,
        rs1_data: id_rs1_data_i,
        rs2_data: id_rs2_data_i,
        imm:      id_imm_i,
        rs1_addr: id_rs1_addr_i,
        rs2_addr: id_rs2_addr_i,
        rd_addr:  id_rd_addr_i,
        funct3:   id_funct3_i,
        funct7b5: id_funct7b5_i
    };

    assign advance  = ~ex_valid_q | ex_ready_i;
    assign rs2_used = ~id_alu_src_select_i | id_mem_write_en_i | id_branch_en_i;

    // In BUBBLE the slot is always empty, so gating on RUN keeps a stall to one cycle
    assign hazard = (state_q == RUN) & id_valid_i & ex_valid_q & ex_ctrl_q.mem_read &
                    (ex_data_q.rd_addr != '0) &
                    ((ex_data_q.rd_addr == id_rs1_addr_i) |
                     (rs2_used & (ex_data_q.rd_addr == id_rs2_addr_i)));

    assign id_ready_o       = flush_i | (advance & ~hazard);
    assign load_use_stall_o = hazard & advance & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_data_q  <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (!advance) begin
            ex_valid_q <= ex_valid_q;
        end else if (hazard) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (id_valid_i) begin
            ex_valid_q <= 1'b1;
            ex_ctrl_q  <= id_ctrl;
            ex_data_q  <= id_data;
        end else begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (load_use_stall_o) state_d = BUBBLE;
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush_i) state_d = RUN;
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (load_use_stall_o)                       bubble_count_o <= bubble_count_o + 32'd1;
            if (flush_i && (ex_valid_q || id_valid_i))  flush_count_o  <= flush_count_o + 32'd1;
        end
    end
`endif

    assign ex_valid_o          = ex_valid_q;
    assign ex_pc_o             = ex_data_q.pc;
    assign ex_rs1_data_o       = ex_data_q.rs1_data;
    assign ex_rs2_data_o       = ex_data_q.rs2_data;
    assign ex_imm_o            = ex_data_q.imm;
    assign ex_rs1_addr_o       = ex_data_q.rs1_addr;
    assign ex_rs2_addr_o       = ex_data_q.rs2_addr;
    assign ex_rd_addr_o        = ex_data_q.rd_addr;
    assign ex_funct3_o         = ex_data_q.funct3;
    assign ex_funct7b5_o       = ex_data_q.funct7b5;
    assign ex_reg_write_en_o   = ex_ctrl_q.reg_write;
    assign ex_mem_read_en_o    = ex_ctrl_q.mem_read;
    assign ex_mem_write_en_o   = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg_o     = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src_select_o = ex_ctrl_q.alu_src;
    assign ex_branch_en_o      = ex_ctrl_q.branch;
    assign ex_alu_op_control_o = ex_ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush/backpressure sequences
// plus a negedge monitor comparing every EX transfer against the queued expectation.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        branch;
        logic [1:0]  alu_op;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst_n, id_valid, flush, ex_ready;
    instr_t cur;
    instr_t ex_obs;
    instr_t sb_q[$];
    int     n_chk = 0, n_fail = 0;

    logic        id_ready, ex_valid, stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_rw, ex_mr, ex_mw, ex_m2r, ex_asel, ex_br;
    logic [1:0]  ex_aluop;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_count, flush_count;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_pc_i(cur.pc), .id_rs1_data_i(cur.rs1_data), .id_rs2_data_i(cur.rs2_data),
        .id_imm_i(cur.imm), .id_rs1_addr_i(cur.rs1_addr), .id_rs2_addr_i(cur.rs2_addr),
        .id_rd_addr_i(cur.rd_addr), .id_funct3_i(cur.funct3), .id_funct7b5_i(cur.funct7b5),
        .id_reg_write_en_i(cur.reg_write), .id_mem_read_en_i(cur.mem_read),
        .id_mem_write_en_i(cur.mem_write), .id_mem_to_reg_i(cur.mem_to_reg),
        .id_alu_src_select_i(cur.alu_src), .id_branch_en_i(cur.branch),
        .id_alu_op_control_i(cur.alu_op),
        .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid),
        .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
        .ex_imm_o(ex_imm), .ex_rs1_addr_o(ex_rs1_addr), .ex_rs2_addr_o(ex_rs2_addr),
        .ex_rd_addr_o(ex_rd_addr), .ex_funct3_o(ex_funct3), .ex_funct7b5_o(ex_funct7b5),
        .ex_reg_write_en_o(ex_rw), .ex_mem_read_en_o(ex_mr), .ex_mem_write_en_o(ex_mw),
        .ex_mem_to_reg_o(ex_m2r), .ex_alu_src_select_o(ex_asel), .ex_branch_en_o(ex_br),
        .ex_alu_op_control_o(ex_aluop),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_count_o(bubble_count), .flush_count_o(flush_count),
`endif
        .load_use_stall_o(stall)
    );

    assign ex_obs = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
                     ex_rd_addr, ex_funct3, ex_funct7b5, ex_rw, ex_mr, ex_mw, ex_m2r,
                     ex_asel, ex_br, ex_aluop};

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                                  input logic mr, mw, asel, br, rw);
        instr_t i;
        i.pc = pc; i.rs1_data = $urandom; i.rs2_data = $urandom; i.imm = $urandom;
        i.rs1_addr = rs1; i.rs2_addr = rs2; i.rd_addr = rd;
        i.funct3 = 3'($urandom); i.funct7b5 = 1'($urandom);
        i.reg_write = rw; i.mem_read = mr; i.mem_write = mw; i.mem_to_reg = mr;
        i.alu_src = asel; i.branch = br;
        i.alu_op = (mr | mw) ? 2'b00 : (br ? 2'b01 : 2'b10);
        return i;
    endfunction

    function automatic instr_t expect_of(input instr_t i);
        instr_t e = i;
        e.reg_write = i.reg_write & (i.rd_addr != 5'd0);
        return e;
    endfunction

    // Pop on each EX handoff, push on each ID acceptance
    always @(negedge clk) begin
        instr_t e;
        if (!rst_n) sb_q.delete();
        else begin
            if (!ex_valid) chk("inv_ctrl", 160'(ex_obs[7:0]), 160'(0));
            if (ex_valid && flush) begin
                if (sb_q.size() != 0) e = sb_q.pop_front();
            end else if (ex_valid && ex_ready) begin
                if (sb_q.size() == 0) chk("sb_empty", 160'(1), 160'(0));
                else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 160'(ex_obs), 160'(e));
                end
            end
            if (id_valid && id_ready && !flush) sb_q.push_back(expect_of(cur));
        end
    end

    task automatic to_neg(); @(negedge clk); endtask
    task automatic to_pos(); @(posedge clk); #1; endtask
    task automatic drive(input instr_t i); cur = i; id_valid = 1'b1; endtask

    instr_t lw5, add6, bp0, bp1;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            id_valid = 1'($urandom); flush = 1'($urandom); ex_ready = 1'($urandom);
            to_neg();
            chk("rst_valid", 160'(ex_valid), 160'(0));
            chk("rst_ctrl", 160'(ex_obs[7:0]), 160'(0));
            chk("rst_pc", 160'(ex_pc), 160'(0));
            chk("rst_ready", 160'(id_ready), 160'(1));
            to_pos();
        end
        rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1;

        lw5  = mk(32'h100, 5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 1);
        add6 = mk(32'h104, 5'd5, 5'd7, 5'd6, 0, 0, 0, 0, 1);
        drive(lw5); to_pos();
        chk("lw_valid", 160'(ex_valid), 160'(1));
        chk("lw_memrd", 160'(ex_mr), 160'(1));
        chk("lw_rd", 160'(ex_rd_addr), 160'(5));

        drive(add6); to_neg();
        chk("lu_stall", 160'(stall), 160'(1));
        chk("lu_ready", 160'(id_ready), 160'(0));
        to_pos();
        chk("lu_bubble", 160'(ex_valid), 160'(0));
        to_neg();
        chk("lu_stall2", 160'(stall), 160'(0));
        chk("lu_ready2", 160'(id_ready), 160'(1));
        to_pos();
        chk("lu_add_in", 160'({ex_valid, ex_rd_addr}), 160'({1'b1, 5'd6}));

        // store uses rs2 even though alu_src selects the immediate
        drive(mk(32'h108, 5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 1)); to_pos();
        drive(mk(32'h10c, 5'd8, 5'd5, 5'd0, 0, 1, 1, 0, 0)); to_neg();
        chk("sw_stall", 160'(stall), 160'(1));
        to_pos(); to_pos();
        chk("sw_in", 160'({ex_valid, ex_mw}), 160'({1'b1, 1'b1}));

        drive(mk(32'h110, 5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 1)); to_pos();
        drive(mk(32'h114, 5'd9, 5'd5, 5'd6, 0, 0, 1, 0, 1)); to_neg();
        chk("addi_nostall", 160'(stall), 160'(0));
        chk("addi_ready", 160'(id_ready), 160'(1));
        to_pos();
        chk("addi_in", 160'({ex_valid, ex_rd_addr}), 160'({1'b1, 5'd6}));

        drive(mk(32'h118, 5'd2, 5'd0, 5'd0, 1, 0, 1, 0, 1)); to_pos();
        chk("lwx0_rw", 160'({ex_rw, ex_mr}), 160'({1'b0, 1'b1}));
        drive(mk(32'h11c, 5'd0, 5'd0, 5'd1, 0, 0, 0, 0, 1)); to_neg();
        chk("x0_nostall", 160'(stall), 160'(0));
        to_pos();
        chk("x0_add_in", 160'({ex_valid, ex_rd_addr, ex_rw}), 160'({1'b1, 5'd1, 1'b1}));
        drive(mk(32'h120, 5'd3, 5'd4, 5'd0, 0, 0, 0, 0, 1)); to_pos();
        chk("rd0_rw", 160'({ex_valid, ex_rw}), 160'({1'b1, 1'b0}));

        bp0 = mk(32'h40, 5'd1, 5'd2, 5'd7, 0, 0, 1, 0, 1);
        bp1 = mk(32'h44, 5'd3, 5'd4, 5'd8, 0, 0, 0, 0, 1);
        drive(bp0); to_pos();
        ex_ready = 1'b0; drive(bp1);
        for (int k = 0; k < 3; k++) begin
            to_neg();
            chk("bp_ready", 160'(id_ready), 160'(0));
            to_pos();
            chk("bp_hold", 160'({ex_valid, ex_obs}), 160'({1'b1, expect_of(bp0)}));
        end
        ex_ready = 1'b1; to_neg();
        chk("bp_release", 160'(id_ready), 160'(1));
        to_pos();
        chk("bp_next", 160'(ex_pc), 160'(32'h44));

        // flush coincident with a load-use hazard on an incoming branch
        drive(mk(32'h200, 5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 1)); to_pos();
        flush = 1'b1; drive(mk(32'h204, 5'd5, 5'd7, 5'd0, 0, 0, 0, 1, 0)); to_neg();
        chk("fl_stall", 160'(stall), 160'(0));
        chk("fl_ready", 160'(id_ready), 160'(1));
        to_pos(); flush = 1'b0;
        chk("fl_valid", 160'(ex_valid), 160'(0));
        chk("fl_branch", 160'(ex_br), 160'(0));
`ifdef ID_EX_PERF_CNT_EN
        chk("fl_count", 160'(flush_count), 160'(1));
        chk("bub_count", 160'(bubble_count), 160'(2));
`endif
        to_neg();
        chk("fl_run", 160'(stall), 160'(0));
        to_pos();
        chk("fl_br_in", 160'({ex_valid, ex_br}), 160'({1'b1, 1'b1}));

        // reset asserted in the middle of a stall
        drive(lw5); to_pos();
        drive(add6); to_neg();
        chk("rs_stall", 160'(stall), 160'(1));
        #2 rst_n = 1'b0; #1;
        chk("rs_async", 160'({ex_valid, ex_obs[7:0]}), 160'(0));
        to_pos(); rst_n = 1'b1;
        to_neg();
        chk("rs_nostall", 160'({stall, id_ready}), 160'({1'b0, 1'b1}));
        to_pos();
        chk("rs_add_in", 160'({ex_valid, ex_rd_addr}), 160'({1'b1, 5'd6}));

        id_valid = 1'b0;
        to_pos(); to_pos();
        chk("sb_drained", 160'(sb_q.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (main control unit plus register file read) and execute.
- Captures the decoded control word and operands, and hands them to EX under a valid/ready handshake.
- Detects load-use hazards and inserts a one-cycle bubble; squashes on a taken-branch flush.
- Guarantees EX never sees live control signals for an invalid slot.

Parameters:
XLEN, 32, datapath width of pc, rs1/rs2 data and immediate
REG_ADDR_W, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid_i  input  1  ID holds an instruction
id_ready_o  output  1  stage accepts the ID instruction this cycle
id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  input  XLEN each  decode operands
id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  input  REG_ADDR_W each  register indices
id_funct3_i  input  3  funct3 field
id_funct7b5_i  input  1  instruction bit 30
id_reg_write_en_i, id_mem_read_en_i, id_mem_write_en_i, id_mem_to_reg_i, id_alu_src_select_i, id_branch_en_i  input  1 each  control word from the control unit
id_alu_op_control_i  input  2  ALU op class
flush_i  input  1  taken branch from EX; kill ID and EX slots
ex_ready_i  input  1  EX accepts its current slot
ex_valid_o  output  1  EX slot holds a live instruction
ex_* (one per id_* input above)  output  same width  registered copies
load_use_stall_o  output  1  hazard bubble being inserted this cycle

Behaviour:
- Reset (rst_n=0, async): ex_valid_o=0; all ex_* data and control outputs 0; FSM=RUN.
- Latency: one cycle from ID acceptance to ex_valid_o.
- advance = ~ex_valid_o | ex_ready_i.
- rs2_used = ~id_alu_src_select_i | id_mem_write_en_i | id_branch_en_i.
- hazard = id_valid_i & ex_valid_o & ex_mem_read_en_o & (ex_rd_addr_o != 0) & ((ex_rd_addr_o == id_rs1_addr_i) | (rs2_used & ex_rd_addr_o == id_rs2_addr_i)).
- id_ready_o = flush_i | (advance & ~hazard). This is combinational; it must not depend on id_valid_i.
- load_use_stall_o = hazard & advance & ~flush_i.
- Next-state priority per clock edge:
  1. flush_i: ex_valid_o<=0, all ex control outputs<=0. Any ID instruction is consumed and discarded.
  2. ~advance: hold every register.
  3. hazard: bubble. ex_valid_o<=0, controls<=0, ID instruction not consumed.
  4. id_valid_i: load all fields, ex_valid_o<=1.
  5. otherwise: ex_valid_o<=0, controls<=0.
- FSM RUN/BUBBLE:
  - RUN->BUBBLE on bubble insertion.
  - BUBBLE->RUN unconditionally next cycle.
  - Because the bubble clears ex_mem_read_en_o, a stall is exactly one cycle per load.
  - Flush in either state returns the FSM to RUN.
- Invariant: ex_valid_o=0 implies all ex control outputs are 0. Data outputs are don't-care but must not be X after reset.
- ex_reg_write_en_o is forced to 0 when id_rd_addr_i==0 at load.
- Back-to-back: with ex_ready_i=1 and no hazard, one instruction transfers per cycle.
- Simultaneous flush and hazard: flush wins, and load_use_stall_o=0.
- Reset asserted mid-stall: the next cycle after release is RUN with an empty slot.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Adds outputs bubble_count_o [31:0] and flush_count_o [31:0], both reset to 0.
  - bubble_count_o increments on each cycle with load_use_stall_o=1.
  - flush_count_o increments on each cycle with flush_i=1 while ex_valid_o=1 or id_valid_i=1.
  - Both wrap modulo 2^32.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> ex_valid_o=0, all controls 0, id_ready_o=1. Release -> first lw (rd=5) appears at EX one cycle later with ex_mem_read_en_o=1.
- Load-use: lw x5 then add x6,x5,x7, ex_ready_i=1 -> one cycle with load_use_stall_o=1, id_ready_o=0, ex_valid_o=0. The add enters EX the following cycle, for a total delay of 1.
- rs2 only via store: lw x5 then sw x5,0(x8) -> stall. lw x5 then addi x6,x9,5 where rs2 field=5 -> no stall.
- x0 destination: lw x0 then add x1,x0,x0 -> no stall. add rd=0 -> ex_reg_write_en_o=0.
- Backpressure: ex_ready_i=0 for 3 cycles with valid slot pc=0x40 -> outputs stable, id_ready_o=0. ex_ready_i=1 -> next instruction loads.
- Flush: flush_i=1 coincident with hazard and id_valid_i -> next cycle ex_valid_o=0, ex_branch_en_o=0, FSM RUN. With ID_EX_PERF_CNT_EN defined, flush_count_o=1 and bubble_count_o unchanged.
